// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch-queue entry layout.
package rv32i_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Misaligned redirect targets are silently forced onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with a synchronous clear that beats push.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential prefetch into a FIFO,
// with redirect flushing and drop counting for in-flight fetches.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h00000000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [31:0] pc_nxt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        instr_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 8;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, last_pc_q, last_pc_d;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, out_after;
  logic            boot_q;

  logic            accept, rsp_take, rsp_keep, rsp_drop, push, pop;
  logic [CW-1:0]   acc_inc, keep_dec, drop_dec;
  logic [AW:0]     fifo_count;
  logic            fifo_full, fifo_empty;
  logic [2*XLEN-1:0] fifo_dout;
  fetch_entry_t    head, in_entry;

  // Request channel: a transfer happens on any cycle with valid & ready; the
  // address only changes after a transfer or on a redirect. Responses are
  // valid-only and arrive in request order.
  assign imem_req_valid = ~rst & ~fifo_full & (out_q < MAXO_C) &
                          ((CW'(fifo_count) + out_q) < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  // Responses with nothing in flight (or right after reset) are stale.
  assign rsp_take = imem_rsp_valid & ~rst & ~boot_q & ((out_q != '0) | (drop_q != '0));
  assign rsp_drop = rsp_take & (drop_q != '0);
  assign rsp_keep = rsp_take & (drop_q == '0);
  assign push     = rsp_keep & ~pc_sel;
  assign pop      = instr_valid & ~stall & ~pc_sel;

  assign acc_inc   = {{(CW-1){1'b0}}, accept};
  assign keep_dec  = {{(CW-1){1'b0}}, rsp_keep};
  assign drop_dec  = {{(CW-1){1'b0}}, rsp_drop};
  assign out_after = out_q + acc_inc - keep_dec;

  assign in_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
  assign head     = fetch_entry_t'(fifo_dout);

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (pc_sel),
    .din   (in_entry),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_after;
    drop_d     = drop_q - drop_dec;
    last_pc_d  = fifo_empty ? last_pc_q : head.pc;
    if (pc_sel) begin
      // Everything still in flight after this cycle must be thrown away.
      fetch_pc_d = align_pc(pc_nxt);
      rsp_pc_d   = align_pc(pc_nxt);
      drop_d     = drop_q - drop_dec + out_after;
      out_d      = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + STEP;
      if (push)   rsp_pc_d   = rsp_pc_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      last_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      boot_q     <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      last_pc_q  <= last_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      boot_q     <= 1'b0;
    end
  end

  assign instr_valid = ~fifo_empty;
  assign instruction = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_out      = fifo_empty ? last_pc_q : head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: variable-latency memory model, expected-pop
// scoreboard and a monitor that checks every instruction decode consumes.
module tb_fetch_queue;
  import rv32i_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] pc_nxt = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        instr_valid;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .pc_sel         (pc_sel),
    .pc_nxt         (pc_nxt),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc_out         (pc_out),
    .instruction    (instruction),
    .instr_valid    (instr_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];
  int budget = 0;
  int lat = 1;
  int cyc = 0;
  bit was_rst = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // ---------------- memory model ----------------
  // In-order responses 'lat' cycles after accept; 'budget' caps total accepts.
  // A junk response is driven in the first cycle after every reset.
  initial begin : mem_model
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst && was_rst) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0BAD0;
      end else if (!rst && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      imem_req_ready = (budget > 0);
      @(negedge clk);
      was_rst = rst;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        acc_log.push_back(imem_req_addr);
        budget--;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && instr_valid && !stall && !pc_sel) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %h instr %h expected none", pc_out, instruction);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", pc_out, mon_e[63:32]);
        chk("pop_instr", instruction, mon_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at posedge+1 of the first cycle after reset.
  task automatic do_reset(input int bud, input int l, input logic st);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pc_sel = 1'b0;
    stall = st;
    budget = bud;
    lat = l;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'h00000013);
    chk("rst_pc_out", pc_out, RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_log.delete();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    next_cycle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    // Back-to-back sequential fetch, latency 1.
    do_reset(6, 1, 1'b0);
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    @(negedge clk);
    chk("t1_c1_addr", imem_req_addr, 32'h0);
    chk("t1_c1_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_c1_ivalid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t1_c2_addr", imem_req_addr, 32'h4);
    chk("t1_c2_ivalid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("t1_c3_addr", imem_req_addr, 32'h8);
    chk("t1_c3_ivalid", {31'b0, instr_valid}, 32'd1);
    drain(40);

    // Stall for 6 cycles: credit limits accepts to DEPTH, head held at pc 0.
    do_reset(8, 1, 1'b1);
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    repeat (6) @(negedge clk);
    chk("t2_accepts", 32'(acc_log.size()), 32'd4);
    chk("t2_head_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_head_pc", pc_out, 32'h0);
    chk("t2_head_instr", instruction, mem_word(32'h0));
    next_cycle();
    stall = 1'b0;
    drain(60);

    // Two fetches (0x10, 0x14) in flight when redirected to 0x100.
    do_reset(0, 4, 1'b0);
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    pc_sel = 1'b1; pc_nxt = 32'h10;
    next_cycle();
    pc_sel = 1'b0; budget = 2;
    next_cycle();
    next_cycle();
    pc_sel = 1'b1; pc_nxt = 32'h100; budget = 3;
    @(negedge clk);
    chk("t3_out_cap", {31'b0, imem_req_valid}, 32'd0);
    chk("t3_accepts", 32'(acc_log.size()), 32'd2);
    next_cycle();
    pc_sel = 1'b0;
    @(negedge clk);
    chk("t3_redir_addr", imem_req_addr, 32'h100);
    drain(60);

    // Redirect in a cycle that also has a response and an accept.
    do_reset(7, 1, 1'b0);
    push_exp(32'h0); push_exp(32'h300); push_exp(32'h304); push_exp(32'h308);
    next_cycle();
    next_cycle();
    next_cycle();
    pc_sel = 1'b1; pc_nxt = 32'h300;
    @(negedge clk);
    chk("t4_rsp_acc_same_cycle", {29'b0, imem_rsp_valid, imem_req_valid, imem_req_ready}, 32'd7);
    next_cycle();
    pc_sel = 1'b0;
    @(negedge clk);
    chk("t4_flushed", {31'b0, instr_valid}, 32'd0);
    drain(60);

    // Request held unaccepted at 0x20, then redirected to a misaligned 0x202.
    do_reset(0, 2, 1'b0);
    push_exp(32'h200); push_exp(32'h204);
    pc_sel = 1'b1; pc_nxt = 32'h20;
    next_cycle();
    pc_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_addr", imem_req_addr, 32'h20);
      chk("t5_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      next_cycle();
    end
    pc_sel = 1'b1; pc_nxt = 32'h202;
    next_cycle();
    pc_sel = 1'b0; budget = 2;
    @(negedge clk);
    chk("t5_redir_addr", imem_req_addr, 32'h200);
    drain(60);
    chk("t5_accepts", 32'(acc_log.size()), 32'd2);
    chk("t5_first_fetch", acc_log[0], 32'h200);

    // Reset while requests are in flight and the FIFO holds entries.
    do_reset(20, 3, 1'b1);
    repeat (6) next_cycle();
    do_reset(2, 1, 1'b0);
    push_exp(32'h0); push_exp(32'h4);
    @(negedge clk);
    chk("t6_ivalid", {31'b0, instr_valid}, 32'd0);
    chk("t6_instruction", instruction, 32'h00000013);
    chk("t6_pc_out", pc_out, RESET_PC);
    chk("t6_req_addr", imem_req_addr, RESET_PC);
    drain(60);
    chk("t6_first_fetch", acc_log[0], RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
